// File: rtl/cpu_pkg.sv
// cpu_pkg: next-PC op encodings and default reset / exception addresses
package cpu_pkg;
  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JR     = 3'd3,
    NPC_JAL    = 3'd4,
    NPC_RET    = 3'd5
  } npc_op_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;
endpackage

// File: rtl/pc_sequencer_ras.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  localparam int AW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [AW-1:0] ptr;
  logic [AW:0] cnt;
  assign top   = mem[AW'(ptr - 1'b1)];
  assign empty = cnt == '0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[ptr] <= din;
      ptr      <= ptr + 1'b1;
      cnt      <= (cnt == (AW+1)'(RAS_DEPTH)) ? cnt : cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with stall hold, deferred redirect and exception vector
// Optional return-address stack is built when NPC_RAS_EN is defined.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEFAULT),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall_i,
  input  logic [2:0]      npc_op_i,
  input  logic            br_take_i,
  input  logic [25:0]     imm_i,
  input  logic [XLEN-1:0] pcjr_i,
  input  logic            exc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] npc_o,
  output logic            redirect_o,
  output logic            ras_uf_o
);
  npc_op_e op;
  logic [XLEN-1:0] pc, p4, br_tgt, jmp_tgt, ret_tgt, op_tgt, pend_tgt;
  logic pend_vld, use_op;
  assign op      = npc_op_e'(npc_op_i);
  assign p4      = pc + XLEN'(4);
  assign br_tgt  = p4 + {{(XLEN-18){imm_i[15]}}, imm_i[15:0], 2'b00};
  assign jmp_tgt = {p4[XLEN-1:28], imm_i, 2'b00};
  // The op only takes effect on an unstalled edge not preempted by exc or a pending redirect
  assign use_op  = !stall_i && !exc_i && !pend_vld;
`ifdef NPC_RAS_EN
  logic [XLEN-1:0] ras_top;
  logic ras_empty;
  ras_stack #(.RAS_DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
    .clk   (clk),
    .rstn  (rstn),
    .push  (use_op && op == NPC_JAL),
    .pop   (use_op && op == NPC_RET),
    .din   (p4),
    .top   (ras_top),
    .empty (ras_empty)
  );
  assign ret_tgt = ras_empty ? pcjr_i : ras_top;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ras_uf_o <= 1'b0;
    else ras_uf_o <= use_op && op == NPC_RET && ras_empty;
  end
`else
  assign ret_tgt  = pcjr_i;
  assign ras_uf_o = 1'b0;
`endif
  assign op_tgt = (op == NPC_BRANCH && br_take_i) ? br_tgt :
                  (op == NPC_JUMP || op == NPC_JAL) ? jmp_tgt :
                  (op == NPC_JR) ? pcjr_i :
                  (op == NPC_RET) ? ret_tgt : p4;
  assign npc_o      = exc_i ? EXC_VEC : pend_vld ? pend_tgt : op_tgt;
  assign redirect_o = npc_o != p4;
  assign pc_o       = pc;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc       <= RESET_PC;
      pend_vld <= 1'b0;
      pend_tgt <= '0;
    end else if (!stall_i) begin
      pc       <= npc_o;
      pend_vld <= 1'b0;
    end else if (exc_i || (!pend_vld && op_tgt != p4)) begin
      pend_tgt <= npc_o;
      pend_vld <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, RAS sequences and randomized model comparison
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rstn, stall_i, br_take_i, exc_i, redirect_o, ras_uf_o;
  logic [2:0] npc_op_i;
  logic [25:0] imm_i;
  logic [31:0] pcjr_i, pc_o, npc_o;
  int checks = 0, errors = 0;
  logic [31:0] cur;
  logic [31:0] m_pc, m_pt;
  logic m_pv, m_uf;
  logic [31:0] q[$];
  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        br;
    logic [25:0] imm;
    logic [31:0] pcjr;
    logic        exc;
    logic [31:0] npc;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[$];

  pc_sequencer dut (
    .clk(clk), .rstn(rstn), .stall_i(stall_i), .npc_op_i(npc_op_i),
    .br_take_i(br_take_i), .imm_i(imm_i), .pcjr_i(pcjr_i), .exc_i(exc_i),
    .pc_o(pc_o), .npc_o(npc_o), .redirect_o(redirect_o), .ras_uf_o(ras_uf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic b,
                       input logic [25:0] im, input logic [31:0] jr, input logic e);
    stall_i = s; npc_op_i = op; br_take_i = b; imm_i = im; pcjr_i = jr; exc_i = e;
  endtask

  task automatic step(input string nm, input logic s, input logic [2:0] op, input logic b,
                      input logic [25:0] im, input logic [31:0] jr, input logic e,
                      input logic [31:0] enpc, input logic [31:0] epc, input logic euf);
    drive(s, op, b, im, jr, e);
    #1;
    chk({nm, " npc"}, npc_o, enpc);
    chk({nm, " redirect"}, 32'(redirect_o), 32'(enpc != cur + 32'd4));
    @(posedge clk);
    #1;
    chk({nm, " pc"}, pc_o, epc);
    chk({nm, " ras_uf"}, 32'(ras_uf_o), 32'(euf));
    cur = epc;
  endtask

  task automatic do_reset();
    drive(0, 3'd0, 0, '0, '0, 0);
    rstn = 1'b0;
    #2;
    chk("reset pc", pc_o, 32'h3000);
    rstn = 1'b1;
    cur = 32'h3000;
    m_pc = 32'h3000; m_pv = 0; m_pt = '0; m_uf = 0;
    q.delete();
  endtask

  // Reference target from the architectural rules, using a queue for the return stack
  function automatic logic [31:0] model_tgt(input logic [2:0] op, input logic b,
                                            input logic [25:0] im, input logic [31:0] jr);
    logic [31:0] p4 = m_pc + 32'd4;
    int signed off = int'($signed(im[15:0])) * 4;
    logic [31:0] jmp = (p4 & 32'hF000_0000) | (32'(im) * 32'd4);
    case (op)
      3'd1: return b ? p4 + 32'(off) : p4;
      3'd2, 3'd4: return jmp;
      3'd3: return jr;
`ifdef NPC_RAS_EN
      3'd5: return (q.size() > 0) ? q[$] : jr;
`else
      3'd5: return jr;
`endif
      default: return p4;
    endcase
  endfunction

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic s, b, e;
      logic [2:0] op;
      logic [25:0] im;
      logic [31:0] jr, p4, tgt, mnpc;
      s  = $urandom_range(0, 3) == 0;
      e  = $urandom_range(0, 15) == 0;
      op = 3'($urandom_range(0, 7));
      b  = 1'($urandom);
      im = 26'($urandom);
      jr = $urandom & 32'hFFFF_FFFC;
      p4 = m_pc + 32'd4;
      tgt = model_tgt(op, b, im, jr);
      mnpc = e ? 32'h4180 : m_pv ? m_pt : tgt;
      drive(s, op, b, im, jr, e);
      #1;
      chk("rand npc", npc_o, mnpc);
      chk("rand redirect", 32'(redirect_o), 32'(mnpc != p4));
      m_uf = 0;
      if (!s) begin
`ifdef NPC_RAS_EN
        if (!e && !m_pv && op == 3'd4) begin
          q.push_back(p4);
          if (q.size() > 4) void'(q.pop_front());
        end else if (!e && !m_pv && op == 3'd5) begin
          if (q.size() > 0) void'(q.pop_back());
          else m_uf = 1;
        end
`endif
        m_pc = mnpc;
        m_pv = 0;
      end else if (e || (!m_pv && tgt != p4)) begin
        m_pt = mnpc;
        m_pv = 1;
      end
      @(posedge clk);
      #1;
      chk("rand pc", pc_o, m_pc);
      chk("rand ras_uf", 32'(ras_uf_o), 32'(m_uf));
    end
  endtask

  initial begin
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h3004,      32'h3004});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h3008,      32'h3008});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h300C,      32'h300C});
    tbl.push_back('{0, 3'd3, 0, 26'h0,      32'h3010,      0, 32'h3010,      32'h3010});
    tbl.push_back('{0, 3'd1, 1, 26'hFFFF,   32'h0,         0, 32'h3010,      32'h3010});
    tbl.push_back('{0, 3'd1, 0, 26'hFFFF,   32'h0,         0, 32'h3014,      32'h3014});
    tbl.push_back('{0, 3'd1, 1, 26'h0010,   32'h0,         0, 32'h3058,      32'h3058});
    tbl.push_back('{0, 3'd3, 0, 26'h0,      32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h0,         32'h0});
    tbl.push_back('{0, 3'd3, 0, 26'h0,      32'h2FFF_FFFC, 0, 32'h2FFF_FFFC, 32'h2FFF_FFFC});
    tbl.push_back('{0, 3'd2, 0, 26'h10,     32'h0,         0, 32'h3000_0040, 32'h3000_0040});
    tbl.push_back('{0, 3'd3, 0, 26'h0,      32'h3000,      0, 32'h3000,      32'h3000});
    tbl.push_back('{1, 3'd3, 0, 26'h0,      32'h5000,      0, 32'h5000,      32'h3000});
    tbl.push_back('{1, 3'd3, 0, 26'h0,      32'h5000,      0, 32'h5000,      32'h3000});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h5000,      32'h5000});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h5004,      32'h5004});
    tbl.push_back('{1, 3'd3, 0, 26'h0,      32'h7000,      0, 32'h7000,      32'h5004});
    tbl.push_back('{0, 3'd2, 0, 26'h123,    32'h0,         1, 32'h4180,      32'h4180});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h4184,      32'h4184});
    tbl.push_back('{1, 3'd0, 0, 26'h0,      32'h0,         1, 32'h4180,      32'h4184});
    tbl.push_back('{1, 3'd3, 0, 26'h0,      32'h9000,      0, 32'h4180,      32'h4184});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h4180,      32'h4180});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h4184,      32'h4184});
    tbl.push_back('{1, 3'd3, 0, 26'h0,      32'h8000,      0, 32'h8000,      32'h4184});
    tbl.push_back('{1, 3'd0, 0, 26'h0,      32'h0,         1, 32'h4180,      32'h4184});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h4180,      32'h4180});
    tbl.push_back('{1, 3'd1, 0, 26'h40,     32'h0,         0, 32'h4184,      32'h4180});
    tbl.push_back('{0, 3'd0, 0, 26'h0,      32'h0,         0, 32'h4184,      32'h4184});
    tbl.push_back('{0, 3'd7, 0, 26'h0,      32'h0,         0, 32'h4188,      32'h4188});
    tbl.push_back('{0, 3'd4, 0, 26'h100,    32'h0,         0, 32'h400,       32'h400});
`ifdef NPC_RAS_EN
    tbl.push_back('{0, 3'd5, 0, 26'h0,      32'h3000,      0, 32'h418C,      32'h418C});
`else
    tbl.push_back('{0, 3'd5, 0, 26'h0,      32'h3000,      0, 32'h3000,      32'h3000});
`endif
    tbl.push_back('{0, 3'd3, 0, 26'h0,      32'h7770,      0, 32'h7770,      32'h7770});

    drive(0, 3'd0, 0, '0, '0, 0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("reset pc", pc_o, 32'h3000);
    chk("reset redirect", 32'(redirect_o), 32'h0);
    chk("reset ras_uf", 32'(ras_uf_o), 32'h0);
    rstn = 1'b1;
    cur = 32'h3000;
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].stall, tbl[i].op, tbl[i].br, tbl[i].imm,
           tbl[i].pcjr, tbl[i].exc, tbl[i].npc, tbl[i].pc, 1'b0);

    drive(1, 3'd3, 0, '0, 32'h5000, 0);
    @(posedge clk);
    #1;
    drive(0, 3'd0, 0, '0, '0, 0);
    #1;
    chk("async pend npc", npc_o, 32'h5000);
    rstn = 1'b0;
    #1;
    chk("async pc", pc_o, 32'h3000);
    chk("async npc", npc_o, 32'h3004);
    rstn = 1'b1;
    cur = 32'h3000;
    step("post async", 0, 3'd0, 0, '0, '0, 0, 32'h3004, 32'h3004, 0);

`ifdef NPC_RAS_EN
    do_reset();
    step("jal pre rst", 0, 3'd4, 0, 26'hC40, '0, 0, 32'h3100, 32'h3100, 0);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    cur = 32'h3000;
    step("ret after rst", 0, 3'd5, 0, '0, 32'h6000, 0, 32'h6000, 32'h6000, 1);
    do_reset();
    step("jal1", 0, 3'd4, 0, 26'hC40, '0, 0, 32'h3100, 32'h3100, 0);
    step("jal2", 0, 3'd4, 0, 26'hC80, '0, 0, 32'h3200, 32'h3200, 0);
    step("ret1", 0, 3'd5, 0, '0, 32'h0, 0, 32'h3104, 32'h3104, 0);
    step("ret2", 0, 3'd5, 0, '0, 32'h0, 0, 32'h3004, 32'h3004, 0);
    step("ret uf", 0, 3'd5, 0, '0, 32'h6000, 0, 32'h6000, 32'h6000, 1);
    step("uf clear", 0, 3'd0, 0, '0, '0, 0, 32'h6004, 32'h6004, 0);
    for (int k = 1; k <= 5; k++)
      step($sformatf("jal5_%0d", k), 0, 3'd4, 0, 26'(k * 32'h400), '0, 0,
           32'(k * 32'h1000), 32'(k * 32'h1000), 0);
    for (int k = 4; k >= 1; k--)
      step($sformatf("pop_%0d", k), 0, 3'd5, 0, '0, 32'h0, 0,
           32'(k * 32'h1000 + 4), 32'(k * 32'h1000 + 4), 0);
    step("oldest lost", 0, 3'd5, 0, '0, 32'hABC0, 0, 32'hABC0, 32'hABC0, 1);
`endif

    do_reset();
    rand_phase(800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
